// File: rtl/random_mwc_pkg.sv
// Shared constants, register map and FSM encoding for the multi-stream MWC RNG.
package random_mwc_pkg;

    localparam logic [2:0] REG_RAND   = 3'd0;
    localparam logic [2:0] REG_STREAM = 3'd1;
    localparam logic [2:0] REG_ZSEED  = 3'd2;
    localparam logic [2:0] REG_WSEED  = 3'd3;
    localparam logic [2:0] REG_CTRL   = 3'd4;

    localparam int          MWC_Z_MULT = 36969;
    localparam int          MWC_W_MULT = 18000;
    localparam logic [31:0] MWC_Z_INIT = 32'd17;
    localparam logic [31:0] MWC_W_INIT = 32'd3;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_READ = 2'd2,
        ST_EXEC = 2'd3
    } mwc_state_e;

    // (mult<<16)-1 maps onto itself under the MWC step, so it must never be stored as a seed.
    function automatic logic [31:0] fixed_point(input int mult);
        return (32'(mult) << 16) - 32'd1;
    endfunction

    // mult*s[15:0] + s[31:16] never exceeds 32 bits for a 16-bit multiplier.
    function automatic logic [31:0] mwc_step(input logic [31:0] s, input logic [15:0] mult);
        return ({16'b0, mult} * {16'b0, s[15:0]}) + {16'b0, s[31:16]};
    endfunction

endpackage

// File: rtl/random_mwc_mstream_if.sv
// Request/response bus between the I/O bridge (master) and the RNG peripheral (slave).
// A request transfers on a rising edge with req_valid_i & req_ready_o; the requester holds
// valid and its payload stable until that edge. resp_valid_o is a one-cycle strobe with no
// back-pressure; resp_dat_o/resp_err_o are meaningful only while it is high.
interface random_mwc_mstream_if;
    import random_mwc_pkg::*;

    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [4:0]  req_adr_i;
    logic [31:0] req_dat_i;
    logic        resp_valid_o;
    logic [31:0] resp_dat_o;
    logic        resp_err_o;
    mwc_state_e  dbg_state;

    modport master (
        output req_valid_i, req_we_i, req_adr_i, req_dat_i,
        input  req_ready_o, resp_valid_o, resp_dat_o, resp_err_o, dbg_state
    );

    modport slave (
        input  req_valid_i, req_we_i, req_adr_i, req_dat_i,
        output req_ready_o, resp_valid_o, resp_dat_o, resp_err_o, dbg_state
    );

endinterface

// File: rtl/mwc_state_ram.sv
// Single-write-port state memory with a registered, enable-gated read (block-RAM style).
module mwc_state_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Read output holds between enables so the datapath can use it for several cycles.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/random_mwc_mstream.sv
// Multi-stream Marsaglia multiply-with-carry RNG as a valid/ready register slave.
// z and w states live in two RAMs; every request runs IDLE -> READ -> EXEC -> IDLE.
module random_mwc_mstream
    import random_mwc_pkg::*;
#(
    parameter int          NSTREAM = 1024,
    parameter int          SW      = $clog2(NSTREAM),
    parameter int          Z_MULT  = MWC_Z_MULT,
    parameter int          W_MULT  = MWC_W_MULT,
    parameter logic [31:0] Z_INIT  = MWC_Z_INIT,
    parameter logic [31:0] W_INIT  = MWC_W_INIT
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    random_mwc_mstream_if.slave bus
);

    localparam logic [SW-1:0] LAST_IDX = SW'(NSTREAM - 1);
    localparam logic [31:0]   Z_FIX    = fixed_point(Z_MULT);
    localparam logic [31:0]   W_FIX    = fixed_point(W_MULT);
    localparam logic [15:0]   ZM       = 16'(Z_MULT);
    localparam logic [15:0]   WM       = 16'(W_MULT);

    mwc_state_e    state_q, state_d;
    logic [SW-1:0] cnt_q;
    logic          we_q;
    logic [2:0]    idx_q;
    logic [31:0]   dat_q;
    logic [SW-1:0] stream_q, stream_d;
    logic          auto_q, auto_d;
    logic          resp_valid_q;
    logic [31:0]   resp_dat_q, resp_dat_d;
    logic          resp_err_q, resp_err_d;

    logic          accept;
    logic          ram_re;
    logic          z_we, w_we;
    logic [SW-1:0] ram_waddr;
    logic [31:0]   z_wdata, w_wdata;
    logic [31:0]   z_rd, w_rd;
    logic [31:0]   z_next, w_next;
    logic [31:0]   rand_val;
    logic          adr_unused;

    assign adr_unused = ^bus.req_adr_i[1:0];

    mwc_state_ram #(.DEPTH(NSTREAM), .AW(SW)) u_z_ram (
        .clk(clk_i), .we(z_we), .waddr(ram_waddr), .wdata(z_wdata),
        .re(ram_re), .raddr(stream_q), .rdata(z_rd)
    );

    mwc_state_ram #(.DEPTH(NSTREAM), .AW(SW)) u_w_ram (
        .clk(clk_i), .we(w_we), .waddr(ram_waddr), .wdata(w_wdata),
        .re(ram_re), .raddr(stream_q), .rdata(w_rd)
    );

    assign z_next   = mwc_step(z_rd, ZM);
    assign w_next   = mwc_step(w_rd, WM);
    assign rand_val = {z_rd[15:0], 16'b0} + w_rd;

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        ram_re     = 1'b0;
        z_we       = 1'b0;
        w_we       = 1'b0;
        ram_waddr  = stream_q;
        z_wdata    = z_rd;
        w_wdata    = w_rd;
        stream_d   = stream_q;
        auto_d     = auto_q;
        resp_dat_d = 32'd0;
        resp_err_d = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                z_we      = 1'b1;
                w_we      = 1'b1;
                ram_waddr = cnt_q;
                z_wdata   = Z_INIT;
                w_wdata   = W_INIT;
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (bus.req_valid_i) begin
                    accept  = 1'b1;
                    ram_re  = 1'b1;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_IDLE;
                case (idx_q)
                    REG_RAND: begin
                        if (!we_q) begin
                            resp_dat_d = rand_val;
                        end
                        // The read returns the pre-advance value; the step commits at this edge.
                        if (we_q || auto_q) begin
                            z_we    = 1'b1;
                            w_we    = 1'b1;
                            z_wdata = z_next;
                            w_wdata = w_next;
                        end
                    end
                    REG_STREAM: begin
                        if (!we_q) begin
                            resp_dat_d = 32'(stream_q);
                        end else if (dat_q >= 32'(NSTREAM)) begin
                            resp_err_d = 1'b1;
                        end else begin
                            stream_d = dat_q[SW-1:0];
                        end
                    end
                    REG_ZSEED: begin
                        if (we_q) begin
                            z_we    = 1'b1;
                            z_wdata = (dat_q == 32'd0 || dat_q == Z_FIX) ? Z_INIT : dat_q;
                        end else begin
                            resp_dat_d = z_rd;
                        end
                    end
                    REG_WSEED: begin
                        if (we_q) begin
                            w_we    = 1'b1;
                            w_wdata = (dat_q == 32'd0 || dat_q == W_FIX) ? W_INIT : dat_q;
                        end else begin
                            resp_dat_d = w_rd;
                        end
                    end
                    REG_CTRL: begin
                        if (we_q) begin
                            auto_d = dat_q[0];
                        end else begin
                            resp_dat_d = {31'b0, auto_q};
                        end
                    end
                    default: begin
                    end
                endcase
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_INIT;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            idx_q        <= 3'd0;
            dat_q        <= 32'd0;
            stream_q     <= '0;
            auto_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_dat_q   <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= (state_q == ST_INIT) ? cnt_q + SW'(1) : '0;
            stream_q     <= stream_d;
            auto_q       <= auto_d;
            resp_valid_q <= (state_q == ST_EXEC);
            resp_dat_q   <= resp_dat_d;
            resp_err_q   <= resp_err_d;
            if (accept) begin
                we_q  <= bus.req_we_i;
                idx_q <= bus.req_adr_i[4:2];
                dat_q <= bus.req_dat_i;
            end
        end
    end

    assign bus.req_ready_o  = (state_q == ST_IDLE);
    assign bus.resp_valid_o = resp_valid_q;
    assign bus.resp_dat_o   = resp_dat_q;
    assign bus.resp_err_o   = resp_err_q;
    assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_random_mwc_mstream.sv
// Bench for random_mwc_mstream (16 streams): reference model of the register map plus a
// per-cycle response checker, directed literal checks and a randomized request stream.
module tb_random_mwc_mstream;

  localparam int NS = 16;

  logic clk;
  logic rst_ni;
  int   cyc;
  int   n_cmp;
  int   n_fail;

  random_mwc_mstream_if bus();

  random_mwc_mstream #(.NSTREAM(NS)) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model
  logic [31:0] mz [NS];
  logic [31:0] mw [NS];
  int          m_stream;
  bit          m_auto;

  function automatic logic [31:0] mwc_adv(input logic [31:0] s, input longint mult);
    longint v;
    v = mult * longint'(s[15:0]) + longint'(s[31:16]);
    return v[31:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      mz[i] = 32'd17;
      mw[i] = 32'd3;
    end
    m_stream = 0;
    m_auto   = 1'b0;
  endtask

  task automatic model_op(input bit we, input logic [4:0] adr, input logic [31:0] dat,
                          output logic [31:0] rd, output bit err);
    rd  = 32'd0;
    err = 1'b0;
    case (adr[4:2])
      3'd0: begin
        if (!we) rd = (mz[m_stream] << 16) + mw[m_stream];
        if (we || m_auto) begin
          mz[m_stream] = mwc_adv(mz[m_stream], 36969);
          mw[m_stream] = mwc_adv(mw[m_stream], 18000);
        end
      end
      3'd1: begin
        if (!we) rd = 32'(m_stream);
        else if (dat >= 32'(NS)) err = 1'b1;
        else m_stream = int'(dat);
      end
      3'd2: begin
        if (!we) rd = mz[m_stream];
        else mz[m_stream] = (dat == 32'd0 || dat == (32'd36969 << 16) - 32'd1) ? 32'd17 : dat;
      end
      3'd3: begin
        if (!we) rd = mw[m_stream];
        else mw[m_stream] = (dat == 32'd0 || dat == (32'd18000 << 16) - 32'd1) ? 32'd3 : dat;
      end
      3'd4: begin
        if (!we) rd = {31'b0, m_auto};
        else m_auto = dat[0];
      end
      default: begin
      end
    endcase
  endtask

  // scoreboard
  logic [31:0] exp_q[$];
  logic        exp_err_q[$];
  int          exp_cyc_q[$];
  logic [31:0] last_dat;
  logic [31:0] prev_dat;
  logic        last_err;

  always @(negedge clk) begin
    if (!rst_ni) begin
      exp_q.delete();
      exp_err_q.delete();
      exp_cyc_q.delete();
    end else if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
      logic [31:0] ed;
      logic        ee;
      void'(exp_cyc_q.pop_front());
      ed = exp_q.pop_front();
      ee = exp_err_q.pop_front();
      n_cmp++;
      if (bus.resp_valid_o !== 1'b1 || bus.resp_dat_o !== ed || bus.resp_err_o !== ee) begin
        n_fail++;
        $display("FAIL resp @cyc %0d: valid=%b dat=0x%08h err=%b, expected valid=1 dat=0x%08h err=%b",
                 cyc, bus.resp_valid_o, bus.resp_dat_o, bus.resp_err_o, ed, ee);
      end
      prev_dat = last_dat;
      last_dat = bus.resp_dat_o;
      last_err = bus.resp_err_o;
    end else if (bus.resp_valid_o !== 1'b0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL spurious_resp @cyc %0d: valid=%b, expected 0", cyc, bus.resp_valid_o);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
    end
  endtask

  // driver: called at (or just after) a falling edge; returns at the falling edge after
  // the accept edge, or after the response when wait_resp is set
  task automatic do_req(input bit we, input logic [4:0] adr, input logic [31:0] dat,
                        input bit wait_resp);
    logic [31:0] rd;
    bit          err;
    int          n;
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = we;
    bus.req_adr_i   = adr;
    bus.req_dat_i   = dat;
    n = 0;
    while (bus.req_ready_o !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (bus.req_ready_o !== 1'b1) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: ready=%b after %0d cycles, expected 1", bus.req_ready_o, n);
      bus.req_valid_i = 1'b0;
      return;
    end
    model_op(we, adr, dat, rd, err);
    exp_q.push_back(rd);
    exp_err_q.push_back(err);
    exp_cyc_q.push_back(cyc + 3);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    chk("ready_busy", 32'(bus.req_ready_o), 32'd0);
    if (wait_resp) begin
      repeat (2) @(negedge clk);
      #1;
    end
  endtask

  // from a falling edge with reset just released: count cycles until ready rises
  task automatic measure_init(input string name);
    int n;
    n = 0;
    while (bus.req_ready_o !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(n), 32'(NS));
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    last_dat = 32'd0;
    prev_dat = 32'd0;
    last_err = 1'b0;
    rst_ni = 1'b0;
    bus.req_valid_i = 1'b0;
    bus.req_we_i    = 1'b0;
    bus.req_adr_i   = 5'd0;
    bus.req_dat_i   = 32'd0;
    model_reset();

    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready_o), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid_o), 32'd0);
    chk("rst_resp_dat", bus.resp_dat_o, 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err_o), 32'd0);

    // valid held high from reset release: ready must appear after the full sweep
    bus.req_valid_i = 1'b1;
    rst_ni = 1'b1;
    measure_init("init_len");
    do_req(1'b0, 5'h00, 32'd0, 1'b1);
    chk("rand_s0_first", last_dat, 32'h0011_0003);

    // stream isolation
    do_req(1'b1, 5'h04, 32'd1, 1'b1);
    do_req(1'b1, 5'h00, 32'hDEAD_BEEF, 1'b0);
    do_req(1'b1, 5'h00, 32'd0, 1'b1);
    do_req(1'b1, 5'h04, 32'd0, 1'b1);
    do_req(1'b0, 5'h00, 32'd0, 1'b1);
    chk("rand_s0_isolated", last_dat, 32'h0011_0003);
    do_req(1'b1, 5'h00, 32'd0, 1'b1);
    do_req(1'b0, 5'h03, 32'd0, 1'b1);
    chk("rand_s0_adv", last_dat, 32'h96F9_D2F0);
    do_req(1'b0, 5'h08, 32'd0, 1'b1);
    chk("zseed_s0_adv", last_dat, 32'h0009_96F9);

    // seed guard on stream 2
    do_req(1'b1, 5'h04, 32'd2, 1'b1);
    do_req(1'b1, 5'h08, 32'd0, 1'b1);
    do_req(1'b0, 5'h08, 32'd0, 1'b1);
    chk("zseed_zero", last_dat, 32'd17);
    do_req(1'b1, 5'h08, 32'h9068_FFFF, 1'b1);
    do_req(1'b0, 5'h08, 32'd0, 1'b1);
    chk("zseed_fixpt", last_dat, 32'd17);
    do_req(1'b1, 5'h0C, 32'h464F_FFFF, 1'b1);
    do_req(1'b0, 5'h0C, 32'd0, 1'b1);
    chk("wseed_fixpt", last_dat, 32'd3);
    do_req(1'b1, 5'h08, 32'd5, 1'b1);
    do_req(1'b0, 5'h08, 32'd0, 1'b1);
    chk("zseed_5", last_dat, 32'd5);

    // stream range check
    do_req(1'b1, 5'h04, 32'd16, 1'b1);
    chk("stream_oob_err", 32'(last_err), 32'd1);
    do_req(1'b0, 5'h04, 32'd0, 1'b1);
    chk("stream_kept", last_dat, 32'd2);
    do_req(1'b1, 5'h04, 32'd15, 1'b1);
    chk("stream_max_err", 32'(last_err), 32'd0);
    do_req(1'b0, 5'h04, 32'd0, 1'b1);
    chk("stream_max", last_dat, 32'd15);
    do_req(1'b0, 5'h1C, 32'd0, 1'b1);
    chk("reg7_zero", last_dat, 32'd0);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      int          r;
      bit          we;
      logic [4:0]  adr;
      logic [31:0] dat;
      r   = $urandom_range(0, 99);
      we  = 1'($urandom_range(0, 1));
      dat = $urandom();
      adr = {3'd0, 2'($urandom_range(0, 3))};
      if (r < 35) adr[4:2] = 3'd0;
      else if (r < 50) begin adr[4:2] = 3'd1; dat = 32'($urandom_range(0, 19)); end
      else if (r < 65) begin
        adr[4:2] = 3'd2;
        if ($urandom_range(0, 5) == 0) dat = 32'd0;
        else if ($urandom_range(0, 5) == 0) dat = 32'h9068_FFFF;
      end else if (r < 80) begin
        adr[4:2] = 3'd3;
        if ($urandom_range(0, 5) == 0) dat = 32'd0;
        else if ($urandom_range(0, 5) == 0) dat = 32'h464F_FFFF;
      end else if (r < 92) adr[4:2] = 3'd4;
      else adr[4:2] = 3'($urandom_range(5, 7));
      do_req(we, adr, dat, 1'($urandom_range(0, 1)));
    end
    repeat (4) @(negedge clk);

    // reset, resweep, then AUTO mode on a fresh stream 0
    rst_ni = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b0;
    bus.req_adr_i   = 5'h10;
    rst_ni = 1'b1;
    measure_init("init_len_2");
    do_req(1'b0, 5'h10, 32'd0, 1'b1);
    chk("ctrl_after_rst", last_dat, 32'd0);
    do_req(1'b1, 5'h10, 32'd1, 1'b1);
    do_req(1'b0, 5'h00, 32'd0, 1'b0);
    do_req(1'b0, 5'h00, 32'd0, 1'b1);
    chk("auto_rand_1", prev_dat, 32'h0011_0003);
    chk("auto_rand_2", last_dat, 32'h96F9_D2F0);

    // reset while the request sits in READ: response dropped, sweep restarts
    do_req(1'b0, 5'h00, 32'd0, 1'b0);
    rst_ni = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    chk("midop_rst_ready", 32'(bus.req_ready_o), 32'd0);
    chk("midop_rst_valid", 32'(bus.resp_valid_o), 32'd0);
    bus.req_valid_i = 1'b1;
    bus.req_adr_i   = 5'h00;
    rst_ni = 1'b1;
    measure_init("init_len_3");
    do_req(1'b0, 5'h00, 32'd0, 1'b1);
    chk("rand_after_midop", last_dat, 32'h0011_0003);
    do_req(1'b0, 5'h00, 32'd0, 1'b1);
    chk("auto_cleared", last_dat, 32'h0011_0003);

    repeat (4) @(negedge clk);
    chk("pending_resp", 32'(exp_cyc_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
